// File: rtl/led_pattern_sequencer_if.sv
// Configuration handshake between the board-control logic and the LED sequencer.
interface led_pattern_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_speed;

    // configuration source
    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_speed,
        input  cfg_ready
    );

    // LED sequencer side
    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_speed,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: prescaled step tick, four patterns, and a
// one-deep config slot that is applied only on step boundaries.
module led_pattern_sequencer #(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int STEPS_PER_SEC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    led_pattern_sequencer_if.slave  cfg,
    output logic [7:0]              leds,
    output logic                    step_pulse,
    output logic [1:0]              mode
);
    localparam int          TICK      = CLK_FREQ / STEPS_PER_SEC;
    localparam logic [31:0] TICK_LAST = 32'(TICK - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_COUNT  = 2'd3;

    logic [31:0] r_presc;
    logic [2:0]  r_spd_cnt;
    logic [2:0]  r_speed;
    logic [1:0]  r_mode;
    logic [7:0]  r_leds;
    logic        r_dir;       // 0 = moving left
    logic        r_pulse;
    logic [0:0]  r_state;
    logic [1:0]  r_pend_mode;
    logic [2:0]  r_pend_speed;

    logic        w_tick;
    logic        w_step;
    logic        w_accept;
    logic [7:0]  w_adv_leds;
    logic        w_adv_dir;
    logic [7:0]  w_start_leds;

    assign w_tick        = (r_presc == TICK_LAST);
    assign w_step        = w_tick && (r_spd_cnt == r_speed);
    assign w_accept      = cfg.cfg_valid && (r_state == S_IDLE);
    assign cfg.cfg_ready = (r_state == S_IDLE);

    assign leds       = r_leds;
    assign step_pulse = r_pulse;
    assign mode       = r_mode;

    // next pattern value for a normal step in the applied mode
    always_comb begin
        w_adv_leds = r_leds;
        w_adv_dir  = r_dir;
        case (r_mode)
            M_OFF:   w_adv_leds = 8'h00;
            M_BLINK: w_adv_leds = ~r_leds;
            M_BOUNCE: begin
                if (!r_dir) begin
                    if (r_leds == 8'h80) begin
                        w_adv_dir  = 1'b1;
                        w_adv_leds = 8'h40;
                    end else begin
                        w_adv_leds = r_leds << 1;
                    end
                end else begin
                    if (r_leds == 8'h01) begin
                        w_adv_dir  = 1'b0;
                        w_adv_leds = 8'h02;
                    end else begin
                        w_adv_leds = r_leds >> 1;
                    end
                end
            end
            default: w_adv_leds = r_leds + 8'd1;
        endcase
    end

    // start value loaded when a pending config is applied
    always_comb begin
        case (r_pend_mode)
            M_BLINK:  w_start_leds = 8'hFF;
            M_BOUNCE: w_start_leds = 8'h01;
            default:  w_start_leds = 8'h00;
        endcase
    end

    // base tick prescaler, free-running 0..TICK-1
    always_ff @(posedge clk) begin
        if (!rst_n)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 32'd1;
    end

    // tick counter selecting every (speed+1)-th tick as a step
    always_ff @(posedge clk) begin
        if (!rst_n)      r_spd_cnt <= '0;
        else if (w_step) r_spd_cnt <= '0;
        else if (w_tick) r_spd_cnt <= r_spd_cnt + 3'd1;
    end

    // config handshake: one slot, freed by the step that applies it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pend_mode  <= M_OFF;
            r_pend_speed <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state      <= S_PENDING;
                    r_pend_mode  <= cfg.cfg_mode;
                    r_pend_speed <= cfg.cfg_speed;
                end
                default: if (w_step) r_state <= S_IDLE;
            endcase
        end
    end

    // pattern state: on a step either apply the pending config or advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leds  <= 8'h00;
            r_dir   <= 1'b0;
            r_mode  <= M_OFF;
            r_speed <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_step;
            if (w_step) begin
                if (r_state == S_PENDING) begin
                    r_mode  <= r_pend_mode;
                    r_speed <= r_pend_speed;
                    r_leds  <= w_start_leds;
                    r_dir   <= 1'b0;
                end else begin
                    r_leds  <= w_adv_leds;
                    r_dir   <= w_adv_dir;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised bench for led_pattern_sequencer with a cycle-level
// behavioural model and a few literal spot checks.
module tb_led_pattern_sequencer;
    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] leds;
    logic       step_pulse;
    logic [1:0] mode;

    led_pattern_sequencer_if ifc();

    led_pattern_sequencer #(.CLK_FREQ(16), .STEPS_PER_SEC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (ifc.slave),
        .leds       (leds),
        .step_pulse (step_pulse),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Steps are spaced (speed+1)*TICK cycles from reset or from the last step;
    // BOUNCE is modelled as a position on a 14-long back-and-forth path.
    int  m_cnt, m_spd, m_mode, m_leds, m_bpos, p_mode, p_spd;
    bit  m_pend, m_pulse, m_ok;

    function automatic int bounce_led(input int pos);
        return (pos < 8) ? (1 << pos) : (1 << (14 - pos));
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            m_cnt = 0; m_spd = 0; m_mode = 0; m_leds = 0; m_bpos = 0;
            m_pend = 0; m_pulse = 0; m_ok = 1;
        end else if (m_ok) begin
            acc = ifc.cfg_valid && !m_pend;
            m_cnt++;
            m_pulse = 0;
            if (m_cnt == (m_spd + 1) * TICK) begin
                m_cnt   = 0;
                m_pulse = 1;
                if (m_pend) begin
                    m_pend = 0;
                    m_mode = p_mode;
                    m_spd  = p_spd;
                    m_bpos = 0;
                    m_leds = (p_mode == 1) ? 8'hFF : (p_mode == 2) ? 8'h01 : 8'h00;
                end else begin
                    case (m_mode)
                        1: m_leds = (~m_leds) & 8'hFF;
                        2: begin m_bpos = (m_bpos + 1) % 14; m_leds = bounce_led(m_bpos); end
                        3: m_leds = (m_leds + 1) % 256;
                        default: m_leds = 0;
                    endcase
                end
            end
            if (acc) begin
                m_pend = 1;
                p_mode = int'(ifc.cfg_mode);
                p_spd  = int'(ifc.cfg_speed);
            end
        end
        #1;
        if (m_ok) begin
            chk("leds",       int'(leds),          m_leds);
            chk("step_pulse", int'(step_pulse),    int'(m_pulse));
            chk("mode",       int'(mode),          m_mode);
            chk("cfg_ready",  int'(ifc.cfg_ready), int'(!m_pend));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int md, input int sp);
        bit got;
        got = 0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_mode  = 2'(md);
        ifc.cfg_speed = 3'(sp);
        for (int k = 0; k < 100; k++) begin
            if (ifc.cfg_ready) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: cfg_ready stayed 0, expected 1");
        end
        @(negedge clk);
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int n);
        for (int j = 0; j < n; j++) begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (step_pulse) begin seen = 1; break; end
            end
            if (!seen) begin
                n_checks++; n_err++;
                $display("FAIL pulse_timeout: step_pulse stayed 0, expected 1");
            end
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        ifc.cfg_valid = 1'b0;
        ifc.cfg_mode  = 2'd0;
        ifc.cfg_speed = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_leds",  int'(leds), 8'h00);
        chk("rst_mode",  int'(mode), 0);
        chk("rst_ready", int'(ifc.cfg_ready), 1);
        chk("rst_pulse", int'(step_pulse), 0);
        rst_n = 1'b1;

        // OFF: pulses while leds stay dark
        wait_pulse(3);
        chk("off_leds", int'(leds), 8'h00);

        // BLINK speed 0
        send(1, 0);
        chk("blink_ready_low", int'(ifc.cfg_ready), 0);
        wait_pulse(1);
        chk("blink_apply", int'(leds), 8'hFF);
        wait_pulse(1);
        chk("blink_toggle", int'(leds), 8'h00);

        // BOUNCE speed 1
        send(2, 1);
        wait_pulse(1);
        chk("bounce_start", int'(leds), 8'h01);
        wait_pulse(7);
        chk("bounce_top", int'(leds), 8'h80);
        wait_pulse(1);
        chk("bounce_turn", int'(leds), 8'h40);
        wait_pulse(6);
        chk("bounce_bottom", int'(leds), 8'h01);
        wait_pulse(1);
        chk("bounce_again", int'(leds), 8'h02);

        // COUNT speed 7 with full wrap
        send(3, 7);
        wait_pulse(1);
        chk("count_start", int'(leds), 8'h00);
        wait_pulse(255);
        chk("count_ff", int'(leds), 8'hFF);
        wait_pulse(1);
        chk("count_wrap", int'(leds), 8'h00);

        // accept coincident with a step edge
        send(1, 0);
        wait_pulse(1);
        wait_pulse(1);
        repeat (3) @(negedge clk);
        send(3, 0);
        chk("coinc_pulse", int'(step_pulse), 1);
        chk("coinc_mode_old", int'(mode), 1);
        chk("coinc_ready", int'(ifc.cfg_ready), 0);
        wait_pulse(1);
        chk("coinc_mode_new", int'(mode), 3);
        chk("coinc_leds", int'(leds), 8'h00);

        // second request held while pending
        send(2, 0);
        send(1, 2);
        chk("held_first_applied", int'(mode), 2);
        wait_pulse(1);
        chk("held_second_applied", int'(mode), 1);
        chk("held_second_leds", int'(leds), 8'hFF);

        // reset while a config is pending during BOUNCE
        send(2, 0);
        wait_pulse(4);
        send(3, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_leds", int'(leds), 8'h00);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_ready", int'(ifc.cfg_ready), 1);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_discarded", int'(mode), 0);

        // random configs, gaps and occasional resets
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
